score_bcd_display: RTL and testbench

Iterative binary-to-BCD converter that sits directly upstream of the per-digit seven-segment decoders on the DE1-SoC HEX displays. It takes a binary game value (score, lives, timer), converts it with a sequential double-dabble (shift-add-3) engine, and presents one 4-bit digit plus one enable per display. The decoders consume `digits_o` and `enables_o` unchanged. Outputs are held stable during conversion, so the displays never flicker.

---
 rtl/score_display_pkg.sv | 14 +
 rtl/score_bcd_display_if.sv | 25 ++
 rtl/bcd_add3.sv | 13 +
 rtl/score_bcd_display.sv | 128 ++++++++++++
 tb/tb_score_bcd_display.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/score_display_pkg.sv
// Shared types and constants for the score BCD display converter.
package score_display_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX_DIGIT = 4'd9;

  // Counter must hold BIN_W itself, hence the +1.
  function automatic int unsigned cnt_width(input int unsigned bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/score_bcd_display_if.sv
// Request/result bundle between a game-logic master and the BCD display converter.
interface score_bcd_display_if #(
    parameter int unsigned BIN_W      = 16,
    parameter int unsigned NUM_DIGITS = 6
);

    logic [BIN_W-1:0]        value_i;
    logic                    load_i;
    logic                    busy_o;
    logic                    valid_o;
    logic [NUM_DIGITS*4-1:0] digits_o;
    logic [NUM_DIGITS-1:0]   enables_o;
    logic                    overflow_o;

    modport master (
        output value_i, load_i,
        input  busy_o, valid_o, digits_o, enables_o, overflow_o
    );

    modport slave (
        input  value_i, load_i,
        output busy_o, valid_o, digits_o, enables_o, overflow_o
    );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble per-nibble correction: add 3 to any digit >= 5; flags non-BCD input.
module bcd_add3
    import score_display_pkg::*;
(
    input  logic [BCD_W-1:0] nibble_i,
    output logic [BCD_W-1:0] nibble_o,
    output logic             ovf_o
);

    assign nibble_o = (nibble_i >= BCD_W'(5)) ? nibble_i + BCD_W'(3) : nibble_i;
    assign ovf_o    = (nibble_i > BCD_MAX_DIGIT);

endmodule

// File: rtl/score_bcd_display.sv
// Sequential binary-to-BCD converter feeding the HEX seven-segment decoders.
// Optional leading-zero blanking of enables_o under macro LEADING_ZERO_BLANK_EN.
module score_bcd_display
    import score_display_pkg::*;
#(
    parameter int unsigned BIN_W      = 16,
    parameter int unsigned NUM_DIGITS = 6
) (
    input logic                clk,
    input logic                reset_n,
    score_bcd_display_if.slave bus
);

    localparam int unsigned ACC_W = NUM_DIGITS * BCD_W;
    localparam int unsigned CNT_W = cnt_width(BIN_W);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   digits_q, digits_d;
    logic               overflow_q, overflow_d;
    logic               valid_q, valid_d;
    logic [ACC_W-1:0]   adj;
    logic [NUM_DIGITS-1:0] nib_ovf;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .nibble_i (bcd_q[i*BCD_W +: BCD_W]),
            .nibble_o (adj[i*BCD_W +: BCD_W]),
            .ovf_o    (nib_ovf[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load_i) begin
                    bin_d   = bus.value_i;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    ovf_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {adj[ACC_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                // A corrected top nibble >= 8 loses its MSB on the shift.
                ovf_d = ovf_q | adj[ACC_W-1] | (|nib_ovf);
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                digits_d   = ovf_q ? {NUM_DIGITS{BCD_MAX_DIGIT}} : bcd_q;
                overflow_d = ovf_q;
                valid_d    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] enables_q, blank_en;
    logic                  seen_nz;

    // Scan from the top digit down; a digit is lit once any digit at or above it is non-zero.
    always_comb begin
        seen_nz  = 1'b0;
        blank_en = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen_nz     = seen_nz | (bcd_q[i*BCD_W +: BCD_W] != '0);
            blank_en[i] = seen_nz;
        end
        blank_en[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enables_q <= NUM_DIGITS'(1);
        end else if (state_q == DONE) begin
            enables_q <= ovf_q ? '1 : blank_en;
        end
    end

    assign bus.enables_o = enables_q;
`else
    assign bus.enables_o = '1;
`endif

    assign bus.busy_o     = (state_q != IDLE);
    assign bus.valid_o    = valid_q;
    assign bus.digits_o   = digits_q;
    assign bus.overflow_o = overflow_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed, table-driven bench for score_bcd_display (16-bit/6-digit and 20-bit/4-digit builds).
module tb_score_bcd_display;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    score_bcd_display_if #(.BIN_W(16), .NUM_DIGITS(6)) ifa ();
    score_bcd_display_if #(.BIN_W(20), .NUM_DIGITS(4)) ifb ();

    score_bcd_display #(.BIN_W(16), .NUM_DIGITS(6)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa.slave)
    );

    score_bcd_display #(.BIN_W(20), .NUM_DIGITS(4)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb.slave)
    );

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    typedef struct {
        logic [15:0] value;
        logic [23:0] digits;
        logic [5:0]  en_blank;
    } vec_t;

    vec_t vecs[9];
    int total = 0;
    int bad = 0;
    logic [23:0] last_a = '0;
    logic [15:0] last_b = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] en_a(input logic [5:0] blank_val);
        return BLANK ? blank_val : 6'h3f;
    endfunction

    function automatic logic [3:0] en_b(input logic [3:0] blank_val);
        return BLANK ? blank_val : 4'hf;
    endfunction

    task automatic run_a(input logic [15:0] v, input logic [23:0] exp_d,
                         input logic [5:0] exp_e, input string tag);
        int busy_cnt;
        bit got;
        ifa.value_i = v;
        ifa.load_i  = 1'b1;
        @(negedge clk);
        ifa.load_i  = 1'b0;
        ifa.value_i = 16'hffff;  // must be ignored mid-conversion
        busy_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (ifa.valid_o) begin
                got = 1'b1;
            end else begin
                if (ifa.busy_o) busy_cnt++;
                if (i == 5) check({tag, "_hold"}, 32'(ifa.digits_o), 32'(last_a));
                @(negedge clk);
            end
        end
        check({tag, "_valid_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, busy_cnt, 32'd17);
        check({tag, "_busy_low"}, 32'(ifa.busy_o), 32'd0);
        check({tag, "_digits"}, 32'(ifa.digits_o), 32'(exp_d));
        check({tag, "_enables"}, 32'(ifa.enables_o), 32'(exp_e));
        check({tag, "_overflow"}, 32'(ifa.overflow_o), 32'd0);
        last_a = exp_d;
        @(negedge clk);
        check({tag, "_valid_pulse"}, 32'(ifa.valid_o), 32'd0);
    endtask

    task automatic run_b(input logic [19:0] v, input logic [15:0] exp_d, input logic [3:0] exp_e,
                         input logic exp_ovf, input string tag);
        int busy_cnt;
        bit got;
        ifb.value_i = v;
        ifb.load_i  = 1'b1;
        @(negedge clk);
        ifb.load_i  = 1'b0;
        busy_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (ifb.valid_o) begin
                got = 1'b1;
            end else begin
                if (ifb.busy_o) busy_cnt++;
                if (i == 5) check({tag, "_hold"}, 32'(ifb.digits_o), 32'(last_b));
                @(negedge clk);
            end
        end
        check({tag, "_valid_seen"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, busy_cnt, 32'd21);
        check({tag, "_digits"}, 32'(ifb.digits_o), 32'(exp_d));
        check({tag, "_enables"}, 32'(ifb.enables_o), 32'(exp_e));
        check({tag, "_overflow"}, 32'(ifb.overflow_o), 32'(exp_ovf));
        last_b = exp_d;
        @(negedge clk);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_digits"}, 32'(ifa.digits_o), 32'd0);
        check({tag, "_enables"}, 32'(ifa.enables_o), 32'(en_a(6'b000001)));
        check({tag, "_busy"}, 32'(ifa.busy_o), 32'd0);
        check({tag, "_valid"}, 32'(ifa.valid_o), 32'd0);
        check({tag, "_overflow"}, 32'(ifa.overflow_o), 32'd0);
    endtask

    initial begin
        int pulses;
        vecs[0] = '{16'd1234,  24'h001234, 6'b001111};
        vecs[1] = '{16'd65535, 24'h065535, 6'b011111};
        vecs[2] = '{16'd0,     24'h000000, 6'b000001};
        vecs[3] = '{16'd9,     24'h000009, 6'b000001};
        vecs[4] = '{16'd10,    24'h000010, 6'b000011};
        vecs[5] = '{16'd100,   24'h000100, 6'b000111};
        vecs[6] = '{16'd1000,  24'h001000, 6'b001111};
        vecs[7] = '{16'd60001, 24'h060001, 6'b011111};
        vecs[8] = '{16'd88,    24'h000088, 6'b000011};

        ifa.value_i = '0;
        ifa.load_i  = 1'b0;
        ifb.value_i = '0;
        ifb.load_i  = 1'b0;

        // Reset state, both during and after reset.
        repeat (2) @(negedge clk);
        check_reset_a("rst_held");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_a("rst_rel");

        for (int k = 0; k < 9; k++) begin
            run_a(vecs[k].value, vecs[k].digits, en_a(vecs[k].en_blank), $sformatf("vec%0d", k));
        end

        // Loads while busy are ignored; one at E3 (SHIFT), one at E17 (DONE).
        ifa.value_i = 16'd42;
        ifa.load_i  = 1'b1;
        @(negedge clk);
        ifa.load_i  = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            if (ifa.valid_o) pulses++;
            if (k == 18) begin
                check("busy_load_valid_e17", 32'(ifa.valid_o), 32'd1);
                check("busy_load_digits", 32'(ifa.digits_o), 32'h000042);
                check("busy_load_enables", 32'(ifa.enables_o), 32'(en_a(6'b000011)));
            end
            if (k == 19) check("busy_load_not_accepted", 32'(ifa.busy_o), 32'd0);
            ifa.load_i  = (k == 3 || k == 17);
            ifa.value_i = ifa.load_i ? 16'd999 : 16'd0;
            @(negedge clk);
        end
        check("busy_load_pulses", pulses, 32'd1);
        check("busy_load_digits_final", 32'(ifa.digits_o), 32'h000042);
        last_a = 24'h000042;

        // Overflow on the narrow-display build, then recovery.
        run_b(20'd10000, 16'h9999, 4'b1111, 1'b1, "ovf");
        run_b(20'd7, 16'h0007, en_b(4'b0001), 1'b0, "ovf_clear");
        run_b(20'd9999, 16'h9999, en_b(4'b1111), 1'b0, "max_fit");

        // Reset mid-conversion after a prior result of 88.
        run_a(16'd88, 24'h000088, en_a(6'b000011), "pre88");
        ifa.value_i = 16'd500;
        ifa.load_i  = 1'b1;
        @(negedge clk);
        ifa.load_i  = 1'b0;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_a("rst_mid");
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ifa.valid_o) pulses++;
        end
        check("rst_mid_no_valid", pulses, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mid_busy_after", 32'(ifa.busy_o), 32'd0);
        last_a = '0;
        run_a(16'd500, 24'h000500, en_a(6'b000111), "post500");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
